// File: rtl/bcd_quiz_pkg.sv
// bcd_quiz_pkg
// Shared types and constants for the BCD quiz round controller.
//   state_t       : round controller states
//   MODE_*        : operation select encodings on the mode input
//   BCD_MAX_DIGIT : largest legal BCD nibble
//   DEFAULT_LIMIT : seconds per question when difficulty is 0
//   sat_add8      : saturating score increment
//   limit_of      : difficulty -> seconds per question
package bcd_quiz_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ANSWER = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ALT = 2'b10;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] DEFAULT_LIMIT = 4'd15;

    // Score never wraps; it pins at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, v} + {7'd0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [3:0] limit_of(input logic [3:0] d);
        return (d == 4'd0) ? DEFAULT_LIMIT : d;
    endfunction

endpackage

// File: rtl/bcd_addsub_n.sv
// bcd_addsub_n
// Combinational N-digit BCD adder / subtractor with decimal carry/borrow.
//   a, b    : DIGITS-digit BCD operands
//   sub     : 1 = a - b (caller guarantees a >= b), 0 = a + b
//   result  : DIGITS+1 digit BCD result (top digit is the carry, 0 for subtract)
//   a_lt_b  : a < b, used by the caller to order subtract operands
module bcd_addsub_n
    import bcd_quiz_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic [4*DIGITS-1:0]     a,
    input  logic [4*DIGITS-1:0]     b,
    input  logic                    sub,
    output logic [4*(DIGITS+1)-1:0] result,
    output logic                    a_lt_b
);

    // cy is a carry for add and a borrow for subtract.
    logic [DIGITS:0]          cy;
    logic [DIGITS-1:0][3:0]   dig;

    assign cy[0] = 1'b0;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            logic [4:0] sum_raw;
            logic [4:0] dif_raw;
            logic       sum_cy;

            assign sum_raw = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + {4'd0, cy[g]};
            assign dif_raw = {1'b0, a[4*g +: 4]} - {1'b0, b[4*g +: 4]} - {4'd0, cy[g]};
            assign sum_cy  = (sum_raw > {1'b0, BCD_MAX_DIGIT});

            // +6 (mod 16) skips the six non-BCD codes on a decimal carry;
            // +10 (mod 16) folds a negative nibble back into 0..9 on a borrow.
            assign dig[g]  = sub ? (dif_raw[4] ? dif_raw[3:0] + 4'd10 : dif_raw[3:0])
                                 : (sum_cy     ? sum_raw[3:0] + 4'd6  : sum_raw[3:0]);
            assign cy[g+1] = sub ? dif_raw[4] : sum_cy;
        end
    endgenerate

    assign result = {(sub ? 4'd0 : {3'd0, cy[DIGITS]}), dig};

    // Packed BCD orders the same as binary, so a plain compare suffices.
    assign a_lt_b = (a < b);

endmodule

// File: rtl/bcd_quiz_engine.sv
// bcd_quiz_engine
// Round controller for the BCD math game: fetches operands, times the
// player's digit-by-digit answer, checks it and keeps score over ROUNDS.
// Optional feature macro: BCD_QUIZ_STREAK_EN (bonus point on every third
// consecutive correct answer).
//   clk, reset            : clock, synchronous active-high reset
//   start                 : begin a game (honoured in IDLE only)
//   sec_tick              : one pulse per second
//   difficulty, mode      : seconds per question (0 -> 15), add/sub/alternate
//   rng_req/valid/a/b     : operand request handshake
//   digit_in, digit_load  : player answer digits, most significant first
//   op_a, op_b, op_sub    : operands and operation shown to the player
//   answer                : digits entered so far, right-aligned
//   time_left, round_num, score, busy : status
//   correct, wrong, bad_digit, game_done : one-cycle event pulses
module bcd_quiz_engine
    import bcd_quiz_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int ROUNDS = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    sec_tick,
    input  logic [3:0]              difficulty,
    input  logic [1:0]              mode,
    output logic                    rng_req,
    input  logic                    rng_valid,
    input  logic [4*DIGITS-1:0]     rng_a,
    input  logic [4*DIGITS-1:0]     rng_b,
    input  logic [3:0]              digit_in,
    input  logic                    digit_load,
    output logic [4*DIGITS-1:0]     op_a,
    output logic [4*DIGITS-1:0]     op_b,
    output logic                    op_sub,
    output logic [4*(DIGITS+1)-1:0] answer,
    output logic [3:0]              time_left,
    output logic [7:0]              round_num,
    output logic [7:0]              score,
    output logic                    busy,
    output logic                    correct,
    output logic                    wrong,
    output logic                    bad_digit,
    output logic                    game_done
);

    localparam int             AW        = 4*(DIGITS+1);
    localparam int             CW        = $clog2(DIGITS+2);
    localparam logic [CW-1:0]  FULL_CNT  = CW'(DIGITS+1);
    localparam logic [CW-1:0]  LAST_CNT  = CW'(DIGITS);
    localparam logic [7:0]     ROUNDS_M1 = 8'(ROUNDS-1);

    state_t          state;
    logic [CW-1:0]   cnt;

    logic [4*DIGITS-1:0] au_a;
    logic [4*DIGITS-1:0] au_b;
    logic [AW-1:0]       au_result;
    logic                au_a_lt_b;

    logic sub_next;
    logic digit_ok;
    logic last_digit;
    logic timeout;
    logic match;
    logic [1:0] score_inc;

    // One arithmetic unit serves both phases: in FETCH it compares the raw
    // RNG operands for the swap, afterwards it computes the expected result
    // from the latched operands.
    assign au_a = (state == FETCH) ? rng_a : op_a;
    assign au_b = (state == FETCH) ? rng_b : op_b;

    bcd_addsub_n #(.DIGITS(DIGITS)) u_addsub (
        .a      (au_a),
        .b      (au_b),
        .sub    (op_sub),
        .result (au_result),
        .a_lt_b (au_a_lt_b)
    );

    always_comb begin
        sub_next = 1'b0;
        case (mode)
            MODE_SUB: sub_next = 1'b1;
            MODE_ALT: sub_next = round_num[0];
            default:  sub_next = 1'b0;
        endcase
    end

    assign digit_ok   = digit_load && (digit_in <= BCD_MAX_DIGIT);
    // The final digit beats a coincident timeout tick.
    assign last_digit = digit_ok && (cnt == LAST_CNT);
    assign timeout    = sec_tick && (time_left == 4'd1);
    assign match      = (cnt == FULL_CNT) && (answer == au_result);

`ifdef BCD_QUIZ_STREAK_EN
    logic [1:0] streak;
    // Two correct already in a row: this one is the third and earns a bonus.
    assign score_inc = (streak == 2'd2) ? 2'd2 : 2'd1;
`else
    assign score_inc = 2'd1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rng_req   <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_sub    <= 1'b0;
            answer    <= '0;
            time_left <= 4'd0;
            round_num <= 8'd0;
            score     <= 8'd0;
            busy      <= 1'b0;
            correct   <= 1'b0;
            wrong     <= 1'b0;
            bad_digit <= 1'b0;
            game_done <= 1'b0;
`ifdef BCD_QUIZ_STREAK_EN
            streak    <= 2'd0;
`endif
        end else begin
            correct   <= 1'b0;
            wrong     <= 1'b0;
            bad_digit <= 1'b0;
            game_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        rng_req   <= 1'b1;
                        busy      <= 1'b1;
                        score     <= 8'd0;
                        round_num <= 8'd0;
`ifdef BCD_QUIZ_STREAK_EN
                        streak    <= 2'd0;
`endif
                    end
                end

                FETCH: begin
                    if (rng_valid) begin
                        // Subtract always presents the larger operand first
                        // so the player never sees a negative result.
                        if (sub_next && au_a_lt_b) begin
                            op_a <= rng_b;
                            op_b <= rng_a;
                        end else begin
                            op_a <= rng_a;
                            op_b <= rng_b;
                        end
                        op_sub    <= sub_next;
                        answer    <= '0;
                        cnt       <= '0;
                        time_left <= limit_of(difficulty);
                        rng_req   <= 1'b0;
                        state     <= ANSWER;
                    end
                end

                ANSWER: begin
                    if (digit_load && !digit_ok)
                        bad_digit <= 1'b1;
                    if (digit_ok) begin
                        answer <= {answer[AW-5:0], digit_in};
                        cnt    <= cnt + CW'(1);
                    end
                    if (sec_tick)
                        time_left <= time_left - 4'd1;
                    if (last_digit || timeout)
                        state <= CHECK;
                end

                CHECK: begin
                    if (match) begin
                        correct <= 1'b1;
                        score   <= sat_add8(score, score_inc);
`ifdef BCD_QUIZ_STREAK_EN
                        streak  <= (streak == 2'd2) ? 2'd0 : streak + 2'd1;
`endif
                    end else begin
                        wrong   <= 1'b1;
`ifdef BCD_QUIZ_STREAK_EN
                        streak  <= 2'd0;
`endif
                    end
                    round_num <= round_num + 8'd1;
                    if (round_num < ROUNDS_M1) begin
                        state   <= FETCH;
                        rng_req <= 1'b1;
                    end else begin
                        state     <= DONE;
                        game_done <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_quiz_engine.sv
// tb_bcd_quiz_engine
// Randomised self-checking bench for bcd_quiz_engine (DIGITS=2, ROUNDS=3).
// The reference works in plain decimal integers: operands, expected result
// and entered answers are numbers; pulses are scheduled by cycle number and
// compared every cycle by a single monitor.
module tb_bcd_quiz_engine;

    localparam int D  = 2;
    localparam int R  = 3;
    localparam int AW = 4*(D+1);

    logic            clk = 1'b0;
    logic            reset, start, sec_tick, rng_req, rng_valid, digit_load;
    logic [3:0]      difficulty, digit_in, time_left;
    logic [1:0]      mode;
    logic [4*D-1:0]  rng_a, rng_b, op_a, op_b;
    logic            op_sub, busy, correct, wrong, bad_digit, game_done;
    logic [AW-1:0]   answer;
    logic [7:0]      round_num, score;

    always #5 clk = ~clk;

    bcd_quiz_engine #(.DIGITS(D), .ROUNDS(R)) dut (
        .clk(clk), .reset(reset), .start(start), .sec_tick(sec_tick),
        .difficulty(difficulty), .mode(mode), .rng_req(rng_req),
        .rng_valid(rng_valid), .rng_a(rng_a), .rng_b(rng_b),
        .digit_in(digit_in), .digit_load(digit_load), .op_a(op_a), .op_b(op_b),
        .op_sub(op_sub), .answer(answer), .time_left(time_left),
        .round_num(round_num), .score(score), .busy(busy), .correct(correct),
        .wrong(wrong), .bad_digit(bad_digit), .game_done(game_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 0;
    // bit0 correct, bit1 wrong, bit2 bad_digit, bit3 game_done
    logic [3:0] exp_pulse [int];

    int m_score, m_round, m_streak;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk)
        if (chk_en)
            chk("pulses{done,bad,wrong,correct}", {28'd0, game_done, bad_digit, wrong, correct},
                {28'd0, exp_pulse.exists(cyc) ? exp_pulse[cyc] : 4'd0});

    task automatic sched(input int c, input int bitn);
        logic [3:0] v;
        v = exp_pulse.exists(c) ? exp_pulse[c] : 4'd0;
        v[bitn] = 1'b1;
        exp_pulse[c] = v;
    endtask

    function automatic logic [4*D-1:0] int2bcd(input int x);
        logic [4*D-1:0] r;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] int2bcdw(input int x);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < D+1; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        start = 0; rng_valid = 0; digit_load = 0; sec_tick = 0;
    endtask

    task automatic start_game();
        start = 1;
        step();
        chk("rng_req 1 cycle after start", rng_req, 1);
        chk("busy after start", busy, 1);
        chk("score cleared by start", score, 0);
        chk("round_num cleared by start", round_num, 0);
        m_score = 0; m_round = 0; m_streak = 0;
    endtask

    // kind: 0 correct, 1 wrong, 2 timeout. ans_val >= 0 forces the digits.
    task automatic do_round(input int a, input int b, input logic [1:0] md,
                            input logic [3:0] diff, input int kind, input int ans_val,
                            input bit noise, input bit bad_first, output bit good);
        int g, ea, eb, expv, value, tl, tl_prev, k, idx, ansval, act, p, inc;
        int tgt[D+1];
        bit sub, ended, ld, bad, tk, fin;
        g = 0;
        while (rng_req !== 1'b1 && g < 20) begin step(); g++; end
        chk("rng_req in FETCH", rng_req, 1);
        if (noise) begin
            repeat ($urandom % 3) begin
                digit_load = 1'($urandom % 2); digit_in = 4'($urandom % 10);
                sec_tick = 1'($urandom % 2); start = ($urandom % 4 == 0);
                step();
                chk("rng_req held in FETCH", rng_req, 1);
            end
        end
        sub = (md == 2'b01) || (md == 2'b10 && (m_round % 2 == 1));
        ea = a; eb = b;
        if (sub && a < b) begin ea = b; eb = a; end
        expv = sub ? ea - eb : ea + eb;
        tl = (diff == 0) ? 15 : int'(diff);
        rng_valid = 1; rng_a = int2bcd(a); rng_b = int2bcd(b); mode = md; difficulty = diff;
        if (noise) begin digit_load = 1'($urandom % 2); digit_in = 4'($urandom % 10); end
        step();
        chk("op_a", op_a, int2bcd(ea));
        chk("op_b", op_b, int2bcd(eb));
        chk("op_sub", op_sub, sub);
        chk("time_left loaded", time_left, tl);
        chk("rng_req dropped", rng_req, 0);
        chk("answer cleared", answer, 0);
        if (noise) begin mode = 2'($urandom); difficulty = 4'($urandom); end

        value = (ans_val >= 0) ? ans_val : expv;
        p = 1;
        for (int i = D; i >= 0; i--) begin tgt[i] = (value / p) % 10; p = p * 10; end
        if (kind == 1) begin
            p = $urandom % (D+1);
            tgt[p] = (tgt[p] + 1 + $urandom % 9) % 10;
        end
        k = (kind == 2) ? (noise ? $urandom % (D+1) : 0) : D+1;

        idx = 0; ansval = 0; ended = 0; g = 0; act = cyc;
        while (!ended && g < 400) begin
            ld  = (idx < k) && (noise ? ($urandom % 3 == 0) : 1'b1);
            bad = !ld && noise && ($urandom % 6 == 0);
            if (bad_first && g == 0) begin ld = 0; bad = 1; end
            fin = ld && (idx == D);
            if (kind == 2 && idx >= k) tk = noise ? 1'($urandom % 2) : 1'b1;
            else tk = noise && ($urandom % 4 == 0) && (tl > 1 || fin);
            digit_load = ld | bad;
            digit_in   = ld ? 4'(tgt[idx]) : (bad ? 4'(10 + $urandom % 6) : 4'($urandom % 10));
            sec_tick   = tk;
            if (noise) start = ($urandom % 8 == 0);
            act = cyc;
            step();
            if (bad) sched(act + 1, 2);
            if (ld) begin ansval = ansval * 10 + tgt[idx]; idx++; end
            tl_prev = tl;
            if (tk) tl--;
            ended = fin || (tk && tl_prev == 1);
            if (!ended) begin
                chk("answer", answer, int2bcdw(ansval));
                chk("time_left", time_left, tl);
            end
            g++;
        end
        chk("round ended", ended, 1);

        good = (idx == D+1) && (ansval == expv);
        m_round++;
        if (good) begin
            inc = 1;
`ifdef BCD_QUIZ_STREAK_EN
            m_streak++;
            if (m_streak == 3) begin inc = 2; m_streak = 0; end
`endif
            m_score = (m_score + inc > 255) ? 255 : m_score + inc;
        end else begin
            m_streak = 0;
        end
        sched(act + 2, good ? 0 : 1);
        if (m_round == R) sched(act + 2, 3);
        step(); step();
        chk("score", score, m_score);
        chk("round_num", round_num, m_round);
        if (m_round == R) begin
            step();
            chk("busy low after DONE", busy, 0);
            chk("rng_req low after DONE", rng_req, 0);
            chk("score held after game", score, m_score);
            chk("round_num held after game", round_num, m_round);
        end
    endtask

    initial begin
        bit good;
        int g;
        reset = 1; start = 0; sec_tick = 0; rng_valid = 0; digit_load = 0;
        digit_in = 0; difficulty = 0; mode = 0; rng_a = 0; rng_b = 0;
        step(); step();
        chk("reset busy", busy, 0);
        chk("reset rng_req", rng_req, 0);
        chk("reset time_left", time_left, 0);
        chk("reset score", score, 0);
        chk("reset round_num", round_num, 0);
        chk("reset answer", answer, 0);
        chk("reset op_a", op_a, 0);
        chk("reset pulses", {game_done, bad_digit, wrong, correct}, 0);
        reset = 0;
        chk_en = 1;
        step();

        // Directed game: 47+85=132 with a bad digit first, 58-23=35, then wrong 36.
        start_game();
        do_round(47, 85, 2'b00, 4'd0, 0, 132, 0, 1, good);
        chk("pin 47+85 model", good, 1);
        chk("pin op_a 47", op_a, 8'h47);
        chk("pin op_sub add", op_sub, 0);
        chk("pin score 1", score, 1);
        do_round(23, 58, 2'b01, 4'd0, 0, 35, 0, 0, good);
        chk("pin 58-23 model", good, 1);
        chk("pin op_a 58", op_a, 8'h58);
        chk("pin op_b 23", op_b, 8'h23);
        chk("pin score 2", score, 2);
        do_round(23, 58, 2'b01, 4'd0, 0, 36, 0, 0, good);
        chk("pin 036 wrong model", good, 0);
        chk("pin score after wrong", score, 2);

        // Alternate mode, all correct: op_sub 0,1,0.
        start_game();
        for (int r = 0; r < R; r++) begin
            do_round($urandom % 100, $urandom % 100, 2'b10, 4'd0, 0, -1, 1, 0, good);
            chk("pin alt op_sub", op_sub, (r == 1) ? 1 : 0);
        end
`ifdef BCD_QUIZ_STREAK_EN
        chk("pin alt score", score, 4);
`else
        chk("pin alt score", score, 3);
`endif

        // Timeout with difficulty 3, then extreme operands.
        start_game();
        do_round(12, 34, 2'b00, 4'd3, 2, -1, 0, 0, good);
        chk("pin timeout score", score, 0);
        do_round(99, 99, 2'b00, 4'd0, 0, -1, 1, 0, good);
        do_round(0, 99, 2'b01, 4'd1, 0, -1, 1, 0, good);
        chk("pin 0-99 op_a", op_a, 8'h99);

        // Reset mid-ANSWER after two digits.
        start_game();
        do_round($urandom % 100, $urandom % 100, 2'b00, 4'd0, 0, -1, 1, 0, good);
        g = 0;
        while (rng_req !== 1'b1 && g < 20) begin step(); g++; end
        rng_valid = 1; rng_a = int2bcd(31); rng_b = int2bcd(22); mode = 0; difficulty = 9;
        step();
        digit_load = 1; digit_in = 0; step();
        digit_load = 1; digit_in = 5; step();
        reset = 1;
        step();
        reset = 0;
        chk("mid reset busy", busy, 0);
        chk("mid reset answer", answer, 0);
        chk("mid reset score", score, 0);
        chk("mid reset round_num", round_num, 0);
        chk("mid reset time_left", time_left, 0);
        chk("mid reset rng_req", rng_req, 0);
        m_score = 0; m_round = 0; m_streak = 0;
        repeat (4) step();

        // Random games.
        repeat (12) begin
            start_game();
            for (int r = 0; r < R; r++)
                do_round($urandom % 100, $urandom % 100, 2'($urandom), 4'($urandom),
                         $urandom % 3, -1, 1, 0, good);
            repeat ($urandom % 3) step();
        end

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
